// File: rtl/fsmc_pkg.sv
// fsmc_pkg
//   Shared definitions for the FSMC sample reader: readout state encoding,
//   flag bit positions of the 16-bit MCU word, default sample count and
//   helpers that build the words presented on FSMC_D.
//   Word formats:
//     ready    : bit 15 set, everything else 0
//     sample   : {1'b0, 1'b1, index[1:0], sample[11:0]}
//     checksum : {2'b11, 2'b00, sum[11:0]}
package fsmc_pkg;

    localparam int DEFAULT_N_SAMPLES = 10000;
    localparam int SAMPLE_W          = 12;
    localparam int WORD_W            = 16;

    localparam int         READY_BIT = 15;
    localparam int         VALID_BIT = 14;
    localparam logic [1:0] CSUM_TAG  = 2'b11;

    localparam logic [WORD_W-1:0] READY_WORD = WORD_W'(1) << READY_BIT;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_READY        = 3'd1,
        ST_FETCH        = 3'd2,
        ST_PRESENT      = 3'd3,
        ST_WAIT_RELEASE = 3'd4,
        ST_DONE         = 3'd5
    } fsmc_state_e;

    function automatic logic [WORD_W-1:0] sample_word(input logic [1:0]          idx_lsb,
                                                      input logic [SAMPLE_W-1:0] sample);
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[VALID_BIT]      = 1'b1;
        w[13:12]          = idx_lsb;
        w[SAMPLE_W-1:0]   = sample;
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] csum_word(input logic [SAMPLE_W-1:0] sum);
        return {CSUM_TAG, 2'b00, sum};
    endfunction

endpackage

// File: rtl/fsmc_sample_reader_if.sv
// fsmc_sample_reader_if
//   Bus bundle between the sample reader, the capture sample RAM and the MCU
//   FSMC port.
//     rd_addr  : sample RAM read address (reader -> RAM)
//     rd_data  : sample RAM data, valid exactly one cycle after rd_addr
//     FPGA_OE  : MCU read strobe, active low, asynchronous to clk_80mhz
//     FSMC_D   : registered 16-bit word to the MCU
//   Strobe semantics: each OE low period requests one word. The word for the
//   current index appears on FSMC_D a fixed number of cycles after the falling
//   edge is seen; the rising edge retires the word (FSMC_D returns to 0) and
//   advances to the next index, even if the word never made it out.
//   Modports: slave = the reader, master = RAM model + MCU side.
interface fsmc_sample_reader_if
    import fsmc_pkg::*;
#(
    parameter int ADDR_W = 14
);
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    logic                FPGA_OE;
    logic [WORD_W-1:0]   FSMC_D;

    modport slave (
        output rd_addr,
        input  rd_data,
        input  FPGA_OE,
        output FSMC_D
    );

    modport master (
        input  rd_addr,
        output rd_data,
        output FPGA_OE,
        input  FSMC_D
    );
endinterface

// File: rtl/fsmc_oe_sync.sv
// fsmc_oe_sync
//   Two-flop synchronizer for the asynchronous MCU read strobe plus edge
//   detection on the synchronized level against its one-cycle-delayed copy.
//   All flops reset to 1 so an inactive strobe produces no edge at reset exit.
//   Ports:
//     clk_i, rst_ni : clock, async active-low reset
//     oe_n_i        : raw FPGA_OE (active low)
//     oe_fall_o     : one-cycle pulse, strobe asserted
//     oe_rise_o     : one-cycle pulse, strobe released
module fsmc_oe_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic oe_n_i,
    output logic oe_fall_o,
    output logic oe_rise_o
);
    logic meta_q;
    logic sync_q;
    logic sync_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q     <= 1'b1;
            sync_q     <= 1'b1;
            sync_dly_q <= 1'b1;
        end else begin
            meta_q     <= oe_n_i;
            sync_q     <= meta_q;
            sync_dly_q <= sync_q;
        end
    end

    assign oe_fall_o = sync_dly_q & ~sync_q;
    assign oe_rise_o = ~sync_dly_q & sync_q;
endmodule

// File: rtl/fsmc_sample_reader.sv
// fsmc_sample_reader
//   Streams a completed capture out of the sample RAM to an MCU over the FSMC
//   bus, one sample per OE strobe. After capture_done the word 16'h8000 tells
//   the MCU data is ready; each strobe then fetches the sample at the current
//   index and presents it tagged with the valid flag and index[1:0].
//   Optional feature (macro FSMC_READER_CHECKSUM_EN): a 12-bit wrap-around sum
//   of all presented samples is returned on one extra strobe before DONE.
//   Ports:
//     clk_80mhz    : single clock
//     rst_n        : async active-low reset (PLL lock)
//     capture_done : level, sample RAM holds a complete capture
//     rearm        : pulse, abandon readout and return to IDLE
//     readout_done : level, all words read
//     state_o      : current readout state (debug)
//     bus          : RAM read port + FSMC strobe/data (slave modport)
module fsmc_sample_reader
    import fsmc_pkg::*;
#(
    parameter int N_SAMPLES = DEFAULT_N_SAMPLES,
    parameter int ADDR_W    = 14
) (
    input  logic                  clk_80mhz,
    input  logic                  rst_n,
    input  logic                  capture_done,
    input  logic                  rearm,
    output logic                  readout_done,
    output fsmc_state_e           state_o,
    fsmc_sample_reader_if.slave   bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

    logic oe_fall;
    logic oe_rise;

    fsmc_oe_sync u_oe_sync (
        .clk_i     (clk_80mhz),
        .rst_ni    (rst_n),
        .oe_n_i    (bus.FPGA_OE),
        .oe_fall_o (oe_fall),
        .oe_rise_o (oe_rise)
    );

    fsmc_state_e       state_q,   state_d;
    logic [ADDR_W-1:0] index_q,   index_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [WORD_W-1:0] fsmc_d_q,  fsmc_d_d;
`ifdef FSMC_READER_CHECKSUM_EN
    logic [SAMPLE_W-1:0] sum_q,        sum_d;
    logic                csum_phase_q, csum_phase_d;
`endif

    always_ff @(posedge clk_80mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            rd_addr_q    <= '0;
            fsmc_d_q     <= '0;
`ifdef FSMC_READER_CHECKSUM_EN
            sum_q        <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            rd_addr_q    <= rd_addr_d;
            fsmc_d_q     <= fsmc_d_d;
`ifdef FSMC_READER_CHECKSUM_EN
            sum_q        <= sum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        rd_addr_d    = rd_addr_q;
        fsmc_d_d     = fsmc_d_q;
`ifdef FSMC_READER_CHECKSUM_EN
        sum_d        = sum_q;
        csum_phase_d = csum_phase_q;
`endif

        if (rearm) begin
            // rearm wins over any strobe edge seen in the same cycle
            state_d      = ST_IDLE;
            index_d      = '0;
            rd_addr_d    = '0;
            fsmc_d_d     = '0;
`ifdef FSMC_READER_CHECKSUM_EN
            sum_d        = '0;
            csum_phase_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture_done) begin
                        state_d  = ST_READY;
                        fsmc_d_d = READY_WORD;
                    end
                end

                // Also the wait state between words; FSMC_D keeps whatever the
                // last release left there (0), so bit 15 is shown only once.
                ST_READY: begin
                    if (oe_fall) begin
                        rd_addr_d = index_q;
                        state_d   = ST_FETCH;
                    end
                end

                ST_FETCH, ST_PRESENT, ST_WAIT_RELEASE: begin
                    if (oe_rise) begin
                        // Release retires the word even if it was never loaded
                        // (short strobe): the pending load is simply dropped.
                        fsmc_d_d = '0;
                        state_d  = ST_READY;
`ifdef FSMC_READER_CHECKSUM_EN
                        if (csum_phase_q) begin
                            state_d = ST_DONE;
                        end else if (index_q == LAST_IDX) begin
                            csum_phase_d = 1'b1;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
`else
                        if (index_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
`endif
                    end else if (state_q == ST_FETCH) begin
                        // rd_addr was registered on the edge; RAM needs one more cycle
                        state_d = ST_PRESENT;
                    end else if (state_q == ST_PRESENT) begin
                        state_d  = ST_WAIT_RELEASE;
`ifdef FSMC_READER_CHECKSUM_EN
                        if (csum_phase_q) begin
                            fsmc_d_d = csum_word(sum_q);
                        end else begin
                            fsmc_d_d = sample_word(index_q[1:0], bus.rd_data);
                            sum_d    = sum_q + bus.rd_data;
                        end
`else
                        fsmc_d_d = sample_word(index_q[1:0], bus.rd_data);
`endif
                    end
                end

                ST_DONE: begin
                    // strobes ignored until rearm or reset
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.FSMC_D   = fsmc_d_q;
    assign readout_done = (state_q == ST_DONE);
    assign state_o      = state_q;
endmodule

// File: tb/tb_fsmc_sample_reader.sv
// tb_fsmc_sample_reader
//   Two reader instances: dut_a (8 samples, RAM holds addr[11:0]) and dut_b
//   (2 samples, RAM holds 12'hFFF, 12'h002). Expected FSMC_D words are queued
//   as stimulus is issued; a monitor compares every change of FSMC_D against
//   the queue head. State, done and reset behaviour are checked directly.
module tb_fsmc_sample_reader;
    import fsmc_pkg::*;

    localparam int ADDR_W = 14;

    logic clk = 1'b0;
    always #6 clk = ~clk;

    logic        rst_n;
    logic        cap_a, cap_b;
    logic        rearm_a, rearm_b;
    logic        done_a, done_b;
    fsmc_state_e st_a, st_b;

    fsmc_sample_reader_if #(.ADDR_W(ADDR_W)) if_a ();
    fsmc_sample_reader_if #(.ADDR_W(ADDR_W)) if_b ();

    fsmc_sample_reader #(.N_SAMPLES(8), .ADDR_W(ADDR_W)) dut_a (
        .clk_80mhz    (clk),
        .rst_n        (rst_n),
        .capture_done (cap_a),
        .rearm        (rearm_a),
        .readout_done (done_a),
        .state_o      (st_a),
        .bus          (if_a)
    );

    fsmc_sample_reader #(.N_SAMPLES(2), .ADDR_W(ADDR_W)) dut_b (
        .clk_80mhz    (clk),
        .rst_n        (rst_n),
        .capture_done (cap_b),
        .rearm        (rearm_b),
        .readout_done (done_b),
        .state_o      (st_b),
        .bus          (if_b)
    );

    // sample RAM models: registered read, one cycle latency
    logic [11:0] ram_a [16];
    logic [11:0] ram_b [16];
    always @(posedge clk) if_a.rd_data <= ram_a[if_a.rd_addr[3:0]];
    always @(posedge clk) if_b.rd_data <= ram_b[if_b.rd_addr[3:0]];

    // scoreboard
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_b = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] e;
        if (if_a.FSMC_D !== prev_a) begin
            n_cmp++;
            if (exp_a.size() == 0) begin
                n_fail++;
                $display("FAIL word_a: got %h with nothing expected", if_a.FSMC_D);
            end else begin
                e = exp_a.pop_front();
                if (if_a.FSMC_D !== e) begin
                    n_fail++;
                    $display("FAIL word_a: got %h expected %h", if_a.FSMC_D, e);
                end
            end
            prev_a = if_a.FSMC_D;
        end
        if (if_b.FSMC_D !== prev_b) begin
            n_cmp++;
            if (exp_b.size() == 0) begin
                n_fail++;
                $display("FAIL word_b: got %h with nothing expected", if_b.FSMC_D);
            end else begin
                e = exp_b.pop_front();
                if (if_b.FSMC_D !== e) begin
                    n_fail++;
                    $display("FAIL word_b: got %h expected %h", if_b.FSMC_D, e);
                end
            end
            prev_b = if_b.FSMC_D;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_oe(input int which, input logic v);
        if (which == 0) if_a.FPGA_OE = v;
        else            if_b.FPGA_OE = v;
    endtask

    task automatic oe_pulse(input int which, input int lo, input int hi);
        set_oe(which, 1'b0);
        repeat (lo) tick();
        set_oe(which, 1'b1);
        repeat (hi) tick();
    endtask

    // hand-computed words for dut_a: {0,1,idx[1:0],idx[11:0]}
    logic [15:0] words_a [8] = '{16'h4000, 16'h5001, 16'h6002, 16'h7003,
                                 16'h4004, 16'h5005, 16'h6006, 16'h7007};

    initial begin
        rst_n       = 1'b0;
        cap_a       = 1'b0;
        cap_b       = 1'b0;
        rearm_a     = 1'b0;
        rearm_b     = 1'b0;
        if_a.FPGA_OE = 1'b1;
        if_b.FPGA_OE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ram_a[i] = 12'(i);
            ram_b[i] = 12'h000;
        end
        ram_b[0] = 12'hFFF;
        ram_b[1] = 12'h002;

        repeat (3) tick();
        check("rst_fsmc_d", 32'(if_a.FSMC_D), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);
        check("rst_rd_addr", 32'(if_a.rd_addr), 32'h0);
        check("rst_state", 32'(st_a), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // strobes while IDLE are ignored
        oe_pulse(1, 6, 6);
        check("idle_ignores_oe", 32'(st_b), 32'(ST_IDLE));

        // ready flag
        exp_a.push_back(16'h8000);
        cap_a = 1'b1;
        tick();
        tick();
        check("ready_word", 32'(if_a.FSMC_D), 32'h8000);
        check("ready_not_done", 32'(done_a), 32'h0);

        // capture_done dropping does not abort
        cap_a = 1'b0;
        tick();
        check("cap_drop_keeps_ready", 32'(st_a), 32'(ST_READY));

        // full readout of 8 samples
        for (int i = 0; i < 8; i++) begin
            exp_a.push_back(words_a[i]);
            exp_a.push_back(16'h0000);
            oe_pulse(0, 6, 6);
        end
`ifdef FSMC_READER_CHECKSUM_EN
        check("csum_not_done_yet", 32'(done_a), 32'h0);
        // 0+1+...+7 = 28 = 12'h01C
        exp_a.push_back(16'hC01C);
        exp_a.push_back(16'h0000);
        oe_pulse(0, 6, 6);
`endif
        tick();
        check("done_after_last", 32'(done_a), 32'h1);
        check("done_state", 32'(st_a), 32'(ST_DONE));
        check("done_fsmc_d", 32'(if_a.FSMC_D), 32'h0);

        // strobes in DONE are ignored
        oe_pulse(0, 6, 6);
        check("done_ignores_oe", 32'(done_a), 32'h1);

        // rearm from DONE
        rearm_a = 1'b1;
        tick();
        rearm_a = 1'b0;
        tick();
        check("rearm_done_clr", 32'(done_a), 32'h0);
        check("rearm_state", 32'(st_a), 32'(ST_IDLE));

        exp_a.push_back(16'h8000);
        cap_a = 1'b1;
        tick();
        tick();

        // short strobe: index 0 is skipped, ready word cleared, nothing stale later
        exp_a.push_back(16'h0000);
        oe_pulse(0, 2, 6);
        exp_a.push_back(16'h5001);
        exp_a.push_back(16'h0000);
        oe_pulse(0, 6, 6);
        exp_a.push_back(16'h6002);
        exp_a.push_back(16'h0000);
        oe_pulse(0, 6, 6);

        // rearm coincident with the fall that would fetch word 3
        set_oe(0, 1'b0);
        tick();
        tick();
        rearm_a = 1'b1;
        exp_a.push_back(16'h8000);
        tick();
        rearm_a = 1'b0;
        check("rearm_fall_state", 32'(st_a), 32'(ST_IDLE));
        check("rearm_fall_fsmc_d", 32'(if_a.FSMC_D), 32'h0);
        repeat (4) tick();
        set_oe(0, 1'b1);
        repeat (6) tick();

        // restart at index 0
        exp_a.push_back(16'h4000);
        exp_a.push_back(16'h0000);
        oe_pulse(0, 6, 6);

        // async reset while word 1 is on the bus
        exp_a.push_back(16'h5001);
        set_oe(0, 1'b0);
        repeat (6) tick();
        check("pre_reset_word", 32'(if_a.FSMC_D), 32'h5001);
        exp_a.push_back(16'h0000);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_fsmc_d", 32'(if_a.FSMC_D), 32'h0);
        check("async_rst_done", 32'(done_a), 32'h0);
        check("async_rst_rd_addr", 32'(if_a.rd_addr), 32'h0);
        set_oe(0, 1'b1);
        tick();
        tick();
        exp_a.push_back(16'h8000);
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_ready", 32'(if_a.FSMC_D), 32'h8000);
        exp_a.push_back(16'h4000);
        exp_a.push_back(16'h0000);
        oe_pulse(0, 6, 6);

        // dut_b: two samples 12'hFFF, 12'h002
        exp_b.push_back(16'h8000);
        cap_b = 1'b1;
        tick();
        tick();
        exp_b.push_back(16'h4FFF);
        exp_b.push_back(16'h0000);
        oe_pulse(1, 6, 6);
        exp_b.push_back(16'h5002);
        exp_b.push_back(16'h0000);
        oe_pulse(1, 6, 6);
`ifdef FSMC_READER_CHECKSUM_EN
        check("b_csum_pending", 32'(done_b), 32'h0);
        exp_b.push_back(16'hC001);
        exp_b.push_back(16'h0000);
        oe_pulse(1, 6, 6);
`endif
        check("b_done", 32'(done_b), 32'h1);

        repeat (4) tick();
        check("exp_a_drained", 32'(exp_a.size()), 32'h0);
        check("exp_b_drained", 32'(exp_b.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
